dsp_mac_acc: RTL and testbench
==============================

Name: dsp_mac_acc

Overview:
Parametrised multiply-accumulate engine, the successor to our single DSP slice. It accepts a stream of signed A×B sample pairs through a valid/ready handshake and multiplies them in a configurable-depth pipeline. It accumulates DOT_LEN products per group, with a per-sample add/subtract select, and emits one rounded, optionally saturated dot-product result per group through an output valid/ready handshake. It sits between sample-stream producers (filter taps, matrix rows) and downstream logic, with full backpressure.

Parameters:
A_WIDTH, 18, signed width of A.
B_WIDTH, 18, signed width of B.
ACC_WIDTH, 48, accumulator width; must be >= A_WIDTH+B_WIDTH.
OUT_WIDTH, 24, width of rounded output P; must be <= ACC_WIDTH.
MULT_STAGES, 2, multiplier pipeline registers; legal range 1..4.
DOT_LEN, 8, products per group; must be >= 1.
SHIFT, 12, arithmetic right shift applied before output; 0 <= SHIFT < ACC_WIDTH.
SAT_EN, 1, 1 = saturate P to OUT_WIDTH signed range; 0 = truncate.

Ports:
CLK  in  1  clock; all logic on rising edge.
RST_N  in  1  synchronous active-low reset.
IN_VALID  in  1  sample pair present.
IN_READY  out  1  engine can accept a sample.
A  in  A_WIDTH  signed multiplicand.
B  in  B_WIDTH  signed multiplier.
SUB  in  1  0 = add this product, 1 = subtract it.
OUT_VALID  out  1  result registers hold a valid group result.
OUT_READY  in  1  downstream accepts the result.
P  out  OUT_WIDTH  rounded, saturated or truncated result.
P_FULL  out  ACC_WIDTH  raw accumulator value for the group.
OVF  out  1  accumulator signed overflow occurred during this group (sticky per group).
SAT  out  1  P was clipped by saturation.

Behaviour:
- Synchronous reset is RST_N low at a rising edge. On reset:
  - Pipeline valid bits, accumulator, sample counter and sticky OVF clear to 0.
  - OUT_VALID, P, P_FULL, OVF and SAT clear to 0.
  - In-flight samples are discarded.
  - IN_READY is 0 while RST_N is low.
- Global enable: EN = !(OUT_VALID && !OUT_READY). IN_READY = EN && RST_N.
  - When EN=0, all multiplier stages, the accumulator, the counter and the sticky OVF freeze.
  - Nothing is dropped while frozen.
- Accept: a sample is taken on an edge where IN_VALID && IN_READY. IN_VALID with IN_READY=0 has no effect.
- Multiplier: stage 1 registers the full signed product A*B (A_WIDTH+B_WIDTH bits) together with SUB and a valid bit. Stages 2..MULT_STAGES shift it forward. Bubbles propagate as invalid.
- Accumulate: on an enabled edge where the last stage is valid:
  - acc_next = acc ± sign_extend(product), computed modulo 2^ACC_WIDTH (wraps).
  - Signed overflow of this add sets the group's sticky OVF.
  - The counter increments.
- Group end: when the counter reaches DOT_LEN-1 and the last stage is valid, on the same edge:
  - P_FULL <= acc_next.
  - P <= post-processed acc_next.
  - OVF <= sticky OR'd with this add's overflow.
  - OUT_VALID <= 1.
  - acc, counter and sticky clear to 0, so the next group may start on the very next product.
- Post-processing:
  - r = (acc_next + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits. This is round-half-up; with SHIFT=0 there is no rounding add.
  - SAT_EN=1: clip r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; SAT=1 if clipped.
  - SAT_EN=0: P = r[OUT_WIDTH-1:0] and SAT = 0.
- Output handshake:
  - OUT_VALID stays high and P, P_FULL, OVF and SAT stay stable until an edge with OUT_READY=1.
  - On that edge OUT_VALID clears, unless a new group completes on the same edge; in that case the new result loads and OUT_VALID stays 1.
- Latency: if the last sample of a group is accepted on edge k, OUT_VALID is high after edge k+MULT_STAGES, given no stall.
- Throughput: 1 sample per cycle sustained with OUT_READY=1.
- DOT_LEN=1: every product produces its own result.

Test Plan:
1. DOT_LEN=4, MULT_STAGES=2, SHIFT=0, OUT_WIDTH=48, SAT_EN=0. Send A=1,2,3,4 with B=2 and SUB=0 back to back; last sample accepted on edge k -> OUT_VALID high after edge k+2, P=P_FULL=20, OVF=0.
2. SUB mix, same configuration: (A=3,B=-5,SUB=0), (A=2,B=7,SUB=1), (A=-4,B=-4,SUB=0), (A=1,B=1,SUB=1) -> P=-15-14+16-1=-14.
3. Backpressure: OUT_READY=0 while 8 samples (two groups) are streamed. First result holds; IN_READY drops right after the first result asserts. Raise OUT_READY for one cycle -> second result (A=5..8, B=1 -> 26) follows; no sample lost or duplicated.
4. Rounding and saturation, SHIFT=4, OUT_WIDTH=8, SAT_EN=1, DOT_LEN=1:
   - A=2040, B=1 -> r=128, so P=127 and SAT=1.
   - A=24, B=1 -> P=2, SAT=0.
   - A=-2100, B=1 -> P=-128, SAT=1.
5. Overflow: ACC_WIDTH=36, DOT_LEN=4, four samples A=B=-131072 -> each product is 2^34; the sum wraps so P_FULL=0, with OVF=1. The next clean group reports OVF=0.
6. Reset mid-group, DOT_LEN=4: accept 2 samples, hold RST_N low for one edge (all outputs 0, IN_READY=0), then send A=1,1,1,1 with B=3 -> P=12.

Source files
------------

// File: rtl/dsp_mac_acc.sv
// dsp_mac_acc: pipelined signed multiply-accumulate with per-group rounded/saturated result and valid/ready handshakes
// Ports:
//   CLK, RST_N         rising-edge clock, synchronous active-low reset
//   IN_VALID/IN_READY  input handshake for one A*B sample; SUB=1 subtracts that product
//   A, B, SUB          signed sample pair and add/subtract select
//   OUT_VALID/OUT_READY output handshake for one group result
//   P, P_FULL          rounded/clipped result and raw group accumulator value
//   OVF, SAT           group accumulator overflow (sticky) and saturation flag
module dsp_mac_acc #(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 48,
  parameter int OUT_WIDTH   = 24,
  parameter int MULT_STAGES = 2,
  parameter int DOT_LEN     = 8,
  parameter int SHIFT       = 12,
  parameter int SAT_EN      = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic signed [A_WIDTH-1:0]   A,
  input  logic signed [B_WIDTH-1:0]   B,
  input  logic                        SUB,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic signed [OUT_WIDTH-1:0] P,
  output logic signed [ACC_WIDTH-1:0] P_FULL,
  output logic                        OVF,
  output logic                        SAT
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int MS = MULT_STAGES;
  localparam int CW = DOT_LEN > 1 ? $clog2(DOT_LEN) : 1;
  localparam int M  = ACC_WIDTH - 1;
  localparam logic [ACC_WIDTH:0] RND = SHIFT == 0 ? '0 : (ACC_WIDTH+1)'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] PMAX = ((ACC_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH:0] PMIN = -PMAX - 1;
  logic                        en, step, grp_done, ovf_add, hi, lo;
  logic signed [PW-1:0]        prod_q [MS];
  logic signed [PW-1:0]        prod_d [MS];
  logic [MS-1:0]               sub_q, sub_d, vld_q, vld_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, ext, acc_next, p_full_q, p_full_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        sticky_q, sticky_d, out_valid_q, out_valid_d;
  logic                        ovf_q, ovf_d, sat_q, sat_d;
  logic signed [OUT_WIDTH-1:0] p_q, p_d;
  logic signed [ACC_WIDTH:0]   rnd_sum, r, clip;
  always_comb begin
    en       = !(out_valid_q && !OUT_READY);
    IN_READY = en && RST_N;
    ext      = ACC_WIDTH'(prod_q[MS-1]);
    acc_next = sub_q[MS-1] ? acc_q - ext : acc_q + ext;
    // overflow: operands effectively share a sign yet the result sign differs
    ovf_add  = ((acc_q[M] ^ ext[M]) == sub_q[MS-1]) && (acc_next[M] != acc_q[M]);
    step     = en && vld_q[MS-1];
    grp_done = step && cnt_q == CW'(DOT_LEN - 1);
    rnd_sum  = {acc_next[M], acc_next} + RND;
    r        = rnd_sum >>> SHIFT;
    hi       = r > PMAX;
    lo       = r < PMIN;
    clip     = SAT_EN != 0 ? (hi ? PMAX : lo ? PMIN : r) : r;
    prod_d   = prod_q;
    sub_d    = sub_q;
    vld_d    = vld_q;
    if (en) begin
      prod_d[0] = A * B;
      sub_d[0]  = SUB;
      vld_d[0]  = IN_VALID && RST_N;
      for (int i = 1; i < MS; i++) begin
        prod_d[i] = prod_q[i-1];
        sub_d[i]  = sub_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (step) begin
      acc_d    = grp_done ? '0 : acc_next;
      cnt_d    = grp_done ? '0 : cnt_q + CW'(1);
      sticky_d = !grp_done && (sticky_q || ovf_add);
    end
    out_valid_d = grp_done || (out_valid_q && !OUT_READY);
    p_d         = grp_done ? clip[OUT_WIDTH-1:0] : p_q;
    p_full_d    = grp_done ? acc_next : p_full_q;
    ovf_d       = grp_done ? (sticky_q || ovf_add) : ovf_q;
    sat_d       = grp_done ? (SAT_EN != 0 && (hi || lo)) : sat_q;
  end
  always_ff @(posedge CLK) begin
    prod_q <= prod_d;
    sub_q  <= sub_d;
    if (!RST_N) begin
      vld_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      p_full_q    <= '0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      p_full_q    <= p_full_d;
      ovf_q       <= ovf_d;
      sat_q       <= sat_d;
    end
  end
  assign OUT_VALID = out_valid_q;
  assign P         = p_q;
  assign P_FULL    = p_full_q;
  assign OVF       = ovf_q;
  assign SAT       = sat_q;
endmodule

// File: tb/tb_dsp_mac_acc.sv
// tb_dsp_mac_acc: directed checks of dsp_mac_acc across three parameter sets
module tb_dsp_mac_acc;
  logic clk, rst_n;
  logic signed [17:0] a, b;
  logic sub;
  logic [2:0] iv, ordy, rdy, ov;
  logic signed [47:0] p1, pf1, pf2;
  logic signed [7:0]  p2;
  logic signed [23:0] p3;
  logic signed [35:0] pf3;
  logic ovf1, sat1, ovf2, sat2, ovf3, sat3;
  int total, bad;

  dsp_mac_acc #(.ACC_WIDTH(48), .OUT_WIDTH(48), .MULT_STAGES(2), .DOT_LEN(4), .SHIFT(0), .SAT_EN(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[0]), .IN_READY(rdy[0]), .A(a), .B(b), .SUB(sub),
    .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .P(p1), .P_FULL(pf1), .OVF(ovf1), .SAT(sat1));
  dsp_mac_acc #(.ACC_WIDTH(48), .OUT_WIDTH(8), .MULT_STAGES(2), .DOT_LEN(1), .SHIFT(4), .SAT_EN(1)) u2 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[1]), .IN_READY(rdy[1]), .A(a), .B(b), .SUB(sub),
    .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .P(p2), .P_FULL(pf2), .OVF(ovf2), .SAT(sat2));
  dsp_mac_acc #(.ACC_WIDTH(36), .OUT_WIDTH(24), .MULT_STAGES(2), .DOT_LEN(4), .SHIFT(12), .SAT_EN(1)) u3 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[2]), .IN_READY(rdy[2]), .A(a), .B(b), .SUB(sub),
    .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .P(p3), .P_FULL(pf3), .OVF(ovf3), .SAT(sat3));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int av, input int bv, input logic s);
    int g;
    a = 18'(av);
    b = 18'(bv);
    sub = s;
    iv[n] = 1;
    g = 0;
    while (!rdy[n] && g < 50) begin
      tick();
      g++;
    end
    total++;
    if (!rdy[n]) begin
      bad++;
      $display("FAIL send_ready dut%0d got in_ready=%0b want 1", n, rdy[n]);
    end
    tick();
  endtask

  task automatic wait_ov(input int n);
    int g;
    g = 0;
    while (!ov[n] && g < 10) begin
      tick();
      g++;
    end
    total++;
    if (!ov[n]) begin
      bad++;
      $display("FAIL out_valid_timeout dut%0d got %0b want 1", n, ov[n]);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick();
    tick();
    total++;
    if (ov !== 3'b000 || rdy !== 3'b000) begin
      bad++;
      $display("FAIL reset_valid_ready got ov=%b rdy=%b want 000/000", ov, rdy);
    end
    total++;
    if (p1 !== 48'sd0 || pf1 !== 48'sd0 || ovf1 !== 1'b0 || sat1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got p=%0d pf=%0d ovf=%0b sat=%0b want 0", p1, pf1, ovf1, sat1);
    end
    rst_n = 1;
    tick();
    total++;
    if (rdy !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_reset got %b want 111", rdy);
    end
  endtask

  task automatic test_sum;
    ordy[0] = 1;
    for (int i = 1; i <= 4; i++) send(0, i, 2, 0);
    iv[0] = 0;
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL sum_latency_k got ov=%0b want 0", ov[0]);
    end
    tick();
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL sum_latency_k1 got ov=%0b want 0", ov[0]);
    end
    tick();
    total++;
    if (ov[0] !== 1'b1 || p1 !== 48'sd20 || pf1 !== 48'sd20 || ovf1 !== 1'b0 || sat1 !== 1'b0) begin
      bad++;
      $display("FAIL sum_result got ov=%0b p=%0d pf=%0d ovf=%0b sat=%0b want 1/20/20/0/0", ov[0], p1, pf1, ovf1, sat1);
    end
    tick();
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL sum_clear got ov=%0b want 0", ov[0]);
    end
  endtask

  task automatic test_sub;
    send(0, 3, -5, 0);
    send(0, 2, 7, 1);
    send(0, -4, -4, 0);
    send(0, 1, 1, 1);
    iv[0] = 0;
    wait_ov(0);
    total++;
    if (p1 !== -48'sd14 || pf1 !== -48'sd14 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL sub_mix got p=%0d pf=%0d ovf=%0b want -14/-14/0", p1, pf1, ovf1);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    ordy[0] = 0;
    for (int i = 1; i <= 6; i++) send(0, i, 1, 0);
    total++;
    if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || p1 !== 48'sd10) begin
      bad++;
      $display("FAIL bp_first got ov=%0b rdy=%0b p=%0d want 1/0/10", ov[0], rdy[0], p1);
    end
    a = 18'sd7;
    iv[0] = 1;
    tick();
    tick();
    tick();
    total++;
    if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || p1 !== 48'sd10) begin
      bad++;
      $display("FAIL bp_hold got ov=%0b rdy=%0b p=%0d want 1/0/10", ov[0], rdy[0], p1);
    end
    ordy[0] = 1;
    tick();
    ordy[0] = 0;
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got ov=%0b want 0", ov[0]);
    end
    send(0, 8, 1, 0);
    iv[0] = 0;
    wait_ov(0);
    total++;
    if (p1 !== 48'sd26 || pf1 !== 48'sd26) begin
      bad++;
      $display("FAIL bp_second got p=%0d pf=%0d want 26", p1, pf1);
    end
    tick();
    total++;
    if (ov[0] !== 1'b1 || p1 !== 48'sd26) begin
      bad++;
      $display("FAIL bp_second_hold got ov=%0b p=%0d want 1/26", ov[0], p1);
    end
    ordy[0] = 1;
    tick();
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got ov=%0b want 0", ov[0]);
    end
  endtask

  task automatic test_round;
    ordy[1] = 1;
    send(1, 2040, 1, 0);
    iv[1] = 0;
    wait_ov(1);
    total++;
    if (p2 !== 8'sd127 || sat2 !== 1'b1 || pf2 !== 48'sd2040 || ovf2 !== 1'b0) begin
      bad++;
      $display("FAIL round_pos_sat got p=%0d sat=%0b pf=%0d want 127/1/2040", p2, sat2, pf2);
    end
    tick();
    send(1, 24, 1, 0);
    iv[1] = 0;
    wait_ov(1);
    total++;
    if (p2 !== 8'sd2 || sat2 !== 1'b0) begin
      bad++;
      $display("FAIL round_half_up got p=%0d sat=%0b want 2/0", p2, sat2);
    end
    tick();
    send(1, -2100, 1, 0);
    iv[1] = 0;
    wait_ov(1);
    total++;
    if (p2 !== -8'sd128 || sat2 !== 1'b1 || pf2 !== -48'sd2100) begin
      bad++;
      $display("FAIL round_neg_sat got p=%0d sat=%0b pf=%0d want -128/1/-2100", p2, sat2, pf2);
    end
    tick();
  endtask

  task automatic test_ovf;
    ordy[2] = 1;
    for (int i = 0; i < 4; i++) send(2, -131072, -131072, 0);
    iv[2] = 0;
    wait_ov(2);
    total++;
    if (pf3 !== 36'sd0 || ovf3 !== 1'b1 || p3 !== 24'sd0 || sat3 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_wrap got pf=%0d ovf=%0b p=%0d sat=%0b want 0/1/0/0", pf3, ovf3, p3, sat3);
    end
    tick();
    for (int i = 0; i < 4; i++) send(2, 1, 1, 0);
    iv[2] = 0;
    wait_ov(2);
    total++;
    if (pf3 !== 36'sd4 || ovf3 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clean got pf=%0d ovf=%0b want 4/0", pf3, ovf3);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    ordy[0] = 1;
    send(0, 9, 9, 0);
    send(0, 9, 9, 0);
    iv[0] = 0;
    rst_n = 0;
    tick();
    total++;
    if (ov[0] !== 1'b0 || rdy[0] !== 1'b0 || p1 !== 48'sd0 || pf1 !== 48'sd0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got ov=%0b rdy=%0b p=%0d pf=%0d ovf=%0b want all 0", ov[0], rdy[0], p1, pf1, ovf1);
    end
    rst_n = 1;
    for (int i = 0; i < 4; i++) send(0, 1, 3, 0);
    iv[0] = 0;
    wait_ov(0);
    total++;
    if (p1 !== 48'sd12 || pf1 !== 48'sd12) begin
      bad++;
      $display("FAIL mid_reset_group got p=%0d pf=%0d want 12", p1, pf1);
    end
    tick();
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_extra got ov=%0b want 0", ov[0]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    iv = '0;
    ordy = '0;
    a = '0;
    b = '0;
    sub = 0;
    rst_n = 0;
    test_reset();
    test_sum();
    test_sub();
    test_back_to_back();
    test_round();
    test_ovf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
